sdram_peri_exerciser: RTL and testbench

Parametrised register-bus sequencer that drives sdram_peri through its byte-wide control port and exercises the SDRAM. It configures the peripheral, fills its transfer buffer with a generated pattern, launches an SDRAM write and/or read, polls for completion, and reads back and compares the buffer. It sits beside sdram_peri as a bring-up and self-test master, and exposes start/done/pass status to a host or LEDs.

---
 rtl/sdram_peri_exerciser_if.sv | 13 +
 rtl/sdram_peri_exerciser.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_sdram_peri_exerciser.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_peri_exerciser_if.sv
// Byte-wide register bus between the exerciser (master) and sdram_peri (slave).
// Writes are single we=1 cycles; reads return dat_r a fixed latency after the address cycle.
interface sdram_peri_exerciser_if #(
  parameter int ADR_W = 14
) ();
  logic [ADR_W-1:0] adr;
  logic             we;
  logic [7:0]       dat_w;
  logic [7:0]       dat_r;

  modport master (output adr, output we, output dat_w, input dat_r);
  modport slave  (input adr, input we, input dat_w, output dat_r);
endinterface

// File: rtl/sdram_peri_exerciser.sv
// Bring-up / self-test master for sdram_peri: configures it, fills the buffer with a
// seeded pattern, runs SDRAM write and/or read, polls status and verifies the read-back.
module sdram_peri_exerciser #(
  parameter int ADR_W        = 14,
  parameter int PAGE         = 1,
  parameter int WORD_BYTES   = 4,
  parameter int MAX_BURST    = 8,
  parameter int INIT_WAIT    = 255,
  parameter int RD_LAT       = 1,
  parameter int POLL_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [7:0]            burst_len,
  input  logic [31:0]           sdram_addr,
  input  logic [31:0]           seed,
  sdram_peri_exerciser_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  cfg_err,
  output logic                  timeout,
  output logic [7:0]            err_count,
  output logic [7:0]            first_err_idx,
  output logic [7:0]            state
);

  localparam logic [ADR_W-10:0] PAGE_B       = PAGE[ADR_W-10:0];
  localparam logic [ADR_W-1:0]  NULL_ADR     = {PAGE_B, 9'd0};
  localparam logic [8:0]        REG_IDX      = 9'd9;
  localparam logic [8:0]        REG_LEN      = 9'd10;
  localparam logic [8:0]        REG_CMD      = 9'd11;
  localparam logic [8:0]        REG_STAT     = 9'd12;
  localparam logic [7:0]        MAX_BURST_L  = MAX_BURST[7:0];
  localparam logic [31:0]       INIT_WAIT_L  = INIT_WAIT;
  localparam logic [31:0]       POLL_TO_L    = POLL_TIMEOUT;
  localparam logic [7:0]        RD_LAT_L     = RD_LAT[7:0];
  localparam logic [3:0]        WB_L         = WORD_BYTES[3:0];
  localparam int                LAST_B_I     = WORD_BYTES - 1;
  localparam logic [2:0]        LAST_BYTE    = LAST_B_I[2:0];
  localparam logic [31:0]       WORD_MASK    = (WORD_BYTES >= 4) ? 32'hFFFF_FFFF
                                               : ((32'd1 << (8 * WORD_BYTES)) - 32'd1);

  typedef enum logic [7:0] {
    S_RESET_WAIT = 8'd0,
    S_IDLE       = 8'd1,
    S_CFG        = 8'd2,
    S_FILL       = 8'd3,
    S_GO         = 8'd4,
    S_POLL       = 8'd5,
    S_VERIFY     = 8'd6,
    S_DONE       = 8'd7
  } state_t;

  state_t           state_r;
  logic [31:0]      wait_cnt_r;
  logic [31:0]      poll_cnt_r;
  logic [7:0]       lat_r;
  logic [3:0]       step_r;
  logic [7:0]       word_r;
  logic [2:0]       byte_r;
  logic [1:0]       sub_r;
  logic             rd_phase_r;
  logic [1:0]       mode_r;
  logic [7:0]       len_r;
  logic [31:0]      addr_r;
  logic [31:0]      seed_r;
  logic [31:0]      asm_r;
  logic [ADR_W-1:0] adr_r;
  logic             we_r;
  logic [7:0]       dat_w_r;
  logic             busy_r;
  logic             done_r;
  logic             pass_r;
  logic             cfg_err_r;
  logic             timeout_r;
  logic [7:0]       err_count_r;
  logic [7:0]       first_err_idx_r;

  logic [31:0]      pat_word_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      poll_next_s;
  logic             rd_cmd_s;

  function automatic logic [31:0] pattern_word(input logic [31:0] s, input logic [7:0] idx);
    logic [31:0] prod;
    prod = {24'd0, idx} * 32'h0101_0101;
    return (s + prod) & WORD_MASK;
  endfunction

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [2:0] b);
    case (b)
      3'd0:    return w[7:0];
      3'd1:    return w[15:8];
      3'd2:    return w[23:16];
      3'd3:    return w[31:24];
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [31:0] set_byte(input logic [31:0] w, input logic [2:0] b,
                                           input logic [7:0] v);
    logic [31:0] r;
    r = w;
    case (b)
      3'd0:    r[7:0]   = v;
      3'd1:    r[15:8]  = v;
      3'd2:    r[23:16] = v;
      3'd3:    r[31:24] = v;
      default: r = w;
    endcase
    return r;
  endfunction

  // Current pattern word, word assembled with the incoming byte, next poll count.
  always_comb begin
    pat_word_s  = pattern_word(seed_r, word_r);
    rd_word_s   = set_byte(asm_r, byte_r, bus.dat_r) & WORD_MASK;
    poll_next_s = poll_cnt_r + 32'd1;
    rd_cmd_s    = rd_phase_r || (mode_r == 2'd1);
  end

  // Run sequencer: state, registered bus drive and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r         <= S_RESET_WAIT;
      wait_cnt_r      <= 32'd0;
      poll_cnt_r      <= 32'd0;
      lat_r           <= 8'd0;
      step_r          <= 4'd0;
      word_r          <= 8'd0;
      byte_r          <= 3'd0;
      sub_r           <= 2'd0;
      rd_phase_r      <= 1'b0;
      mode_r          <= 2'd0;
      len_r           <= 8'd0;
      addr_r          <= 32'd0;
      seed_r          <= 32'd0;
      asm_r           <= 32'd0;
      adr_r           <= NULL_ADR;
      we_r            <= 1'b0;
      dat_w_r         <= 8'd0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      pass_r          <= 1'b0;
      cfg_err_r       <= 1'b0;
      timeout_r       <= 1'b0;
      err_count_r     <= 8'd0;
      first_err_idx_r <= 8'hFF;
    end else begin
      adr_r   <= NULL_ADR;
      we_r    <= 1'b0;
      dat_w_r <= 8'd0;
      done_r  <= 1'b0;
      case (state_r)
        S_RESET_WAIT: begin
          if ((wait_cnt_r + 32'd1) >= INIT_WAIT_L) begin
            state_r <= S_IDLE;
          end else begin
            wait_cnt_r <= wait_cnt_r + 32'd1;
          end
        end
        S_IDLE: begin
          if (start) begin
            mode_r     <= (mode == 2'd3) ? 2'd2 : mode;
            len_r      <= burst_len;
            addr_r     <= sdram_addr;
            seed_r     <= seed;
            busy_r     <= 1'b1;
            pass_r     <= 1'b0;
            rd_phase_r <= 1'b0;
            step_r     <= 4'd0;
            word_r     <= 8'd0;
            if ((burst_len == 8'd0) || (burst_len > MAX_BURST_L)) begin
              cfg_err_r <= 1'b1;
              state_r   <= S_DONE;
            end else begin
              cfg_err_r       <= 1'b0;
              timeout_r       <= 1'b0;
              err_count_r     <= 8'd0;
              first_err_idx_r <= 8'hFF;
              state_r         <= S_CFG;
            end
          end
        end
        S_CFG: begin
          we_r    <= 1'b1;
          adr_r   <= {PAGE_B, (step_r == 4'd0) ? REG_LEN : {5'd0, step_r}};
          dat_w_r <= (step_r == 4'd0) ? len_r : pick_byte(addr_r, step_r[2:0] - 3'd1);
          if (step_r == 4'd4) begin
            step_r  <= 4'd0;
            word_r  <= 8'd0;
            state_r <= rd_cmd_s ? S_GO : S_FILL;
          end else begin
            step_r <= step_r + 4'd1;
          end
        end
        S_FILL: begin
          we_r <= 1'b1;
          if (step_r == 4'd0) begin
            adr_r   <= {PAGE_B, REG_IDX};
            dat_w_r <= word_r;
          end else begin
            adr_r   <= {PAGE_B, 9'd4 + {5'd0, step_r}};
            dat_w_r <= pick_byte(pat_word_s, step_r[2:0] - 3'd1);
          end
          if (step_r == WB_L) begin
            step_r <= 4'd0;
            if (word_r == (len_r - 8'd1)) begin
              state_r <= S_GO;
            end else begin
              word_r <= word_r + 8'd1;
            end
          end else begin
            step_r <= step_r + 4'd1;
          end
        end
        S_GO: begin
          we_r       <= 1'b1;
          adr_r      <= {PAGE_B, REG_CMD};
          dat_w_r    <= rd_cmd_s ? 8'd1 : 8'd0;
          step_r     <= 4'd0;
          poll_cnt_r <= 32'd0;
          state_r    <= S_POLL;
        end
        // Steps 0/1 are the settle cycles, 2 issues a status read, 3 waits for dat_r.
        S_POLL: begin
          if (step_r < 4'd2) begin
            step_r <= step_r + 4'd1;
          end else if (step_r == 4'd2) begin
            adr_r  <= {PAGE_B, REG_STAT};
            lat_r  <= 8'd0;
            step_r <= 4'd3;
          end else if (lat_r == RD_LAT_L) begin
            poll_cnt_r <= poll_next_s;
            if (!bus.dat_r[0]) begin
              if (mode_r == 2'd0) begin
                state_r <= S_DONE;
              end else if ((mode_r == 2'd2) && !rd_phase_r) begin
                rd_phase_r <= 1'b1;
                step_r     <= 4'd0;
                state_r    <= S_CFG;
              end else begin
                word_r  <= 8'd0;
                sub_r   <= 2'd0;
                state_r <= S_VERIFY;
              end
            end else if (poll_next_s >= POLL_TO_L) begin
              timeout_r <= 1'b1;
              pass_r    <= 1'b0;
              state_r   <= S_DONE;
            end else begin
              step_r <= 4'd2;
            end
          end else begin
            lat_r <= lat_r + 8'd1;
          end
        end
        S_VERIFY: begin
          case (sub_r)
            2'd0: begin
              we_r    <= 1'b1;
              adr_r   <= {PAGE_B, REG_IDX};
              dat_w_r <= word_r;
              byte_r  <= 3'd0;
              asm_r   <= 32'd0;
              sub_r   <= 2'd1;
            end
            2'd1: begin
              adr_r <= {PAGE_B, 9'd5 + {6'd0, byte_r}};
              lat_r <= 8'd0;
              sub_r <= 2'd2;
            end
            default: begin
              if (lat_r == RD_LAT_L) begin
                asm_r <= rd_word_s;
                if (byte_r == LAST_BYTE) begin
                  if ((mode_r == 2'd2) && (rd_word_s != pat_word_s)) begin
                    if (err_count_r != 8'hFF) begin
                      err_count_r <= err_count_r + 8'd1;
                    end
                    if (first_err_idx_r == 8'hFF) begin
                      first_err_idx_r <= word_r;
                    end
                  end
                  if (word_r == (len_r - 8'd1)) begin
                    state_r <= S_DONE;
                  end else begin
                    word_r <= word_r + 8'd1;
                    sub_r  <= 2'd0;
                  end
                end else begin
                  byte_r <= byte_r + 3'd1;
                  sub_r  <= 2'd1;
                end
              end else begin
                lat_r <= lat_r + 8'd1;
              end
            end
          endcase
        end
        S_DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          pass_r  <= !timeout_r && (err_count_r == 8'd0) && !cfg_err_r;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.adr       = adr_r;
  assign bus.we        = we_r;
  assign bus.dat_w     = dat_w_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pass          = pass_r;
  assign cfg_err       = cfg_err_r;
  assign timeout       = timeout_r;
  assign err_count     = err_count_r;
  assign first_err_idx = first_err_idx_r;
  assign state         = state_r;

endmodule

// File: tb/tb_sdram_peri_exerciser.sv
// Bench for sdram_peri_exerciser: a behavioural sdram_peri responder, a scoreboard of
// expected register writes, a table of runs and hand-written reset/start corner cases.
module tb_sdram_peri_exerciser;
  localparam int ADR_W = 14, PAGE = 1, WB = 4, MAX_BURST = 8, INIT_WAIT = 255;
  localparam int RD_LAT = 1, POLL_TO = 24;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [7:0]  burst_len = 8'd0;
  logic [31:0] sdram_addr = 32'd0, seed = 32'd0;
  logic        busy, done, pass, cfg_err, timeout;
  logic [7:0]  err_count, first_err_idx, state;

  sdram_peri_exerciser_if #(.ADR_W(ADR_W)) bus_if ();

  sdram_peri_exerciser #(
    .ADR_W(ADR_W), .PAGE(PAGE), .WORD_BYTES(WB), .MAX_BURST(MAX_BURST),
    .INIT_WAIT(INIT_WAIT), .RD_LAT(RD_LAT), .POLL_TIMEOUT(POLL_TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .burst_len(burst_len),
    .sdram_addr(sdram_addr), .seed(seed), .bus(bus_if), .busy(busy), .done(done),
    .pass(pass), .cfg_err(cfg_err), .timeout(timeout), .err_count(err_count),
    .first_err_idx(first_err_idx), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  len;
    logic [31:0] addr;
    logic [31:0] seed;
    int          busy_n;
    bit          stuck;
    bit          corrupt;
    bit          e_pass;
    bit          e_cfg;
    bit          e_to;
    logic [7:0]  e_errs;
    logic [7:0]  e_first;
    int          e_polls;
    int          e_reads;
  } vec_t;

  int          n_checks = 0, n_pass = 0;
  int          polls = 0, dreads = 0;
  logic [31:0] exp_q[$];
  vec_t        vecs[9];

  // Responder model state
  logic [7:0]  m_idx = 8'd0;
  logic [31:0] m_buf [0:MAX_BURST-1];
  int          m_busy_left = 0;
  int          cfg_busy_n = 0;
  bit          cfg_stuck = 1'b0, cfg_corrupt = 1'b0;
  wire  [8:0]  reg_a = bus_if.adr[8:0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int b);
    case (b)
      0:       return w[7:0];
      1:       return w[15:8];
      2:       return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  // Behavioural sdram_peri: buffer registers, command-triggered busy period, RD_LAT=1 reads.
  always @(posedge clk) begin
    logic [7:0] v;
    if (bus_if.we) begin
      case (reg_a)
        9'd5:  m_buf[m_idx[2:0]][7:0]   <= bus_if.dat_w;
        9'd6:  m_buf[m_idx[2:0]][15:8]  <= bus_if.dat_w;
        9'd7:  m_buf[m_idx[2:0]][23:16] <= bus_if.dat_w;
        9'd8:  m_buf[m_idx[2:0]][31:24] <= bus_if.dat_w;
        9'd9:  m_idx <= bus_if.dat_w;
        9'd11: m_busy_left <= cfg_busy_n;
        default: ;
      endcase
      bus_if.dat_r <= 8'd0;
    end else if (reg_a == 9'd12) begin
      bus_if.dat_r <= (cfg_stuck || m_busy_left != 0) ? 8'd1 : 8'd0;
      if (m_busy_left != 0) m_busy_left <= m_busy_left - 1;
    end else if (reg_a >= 9'd5 && reg_a <= 9'd8) begin
      v = byte_of(m_buf[m_idx[2:0]], int'(reg_a) - 5);
      if (cfg_corrupt && m_idx == 8'd2 && reg_a == 9'd6) v = v ^ 8'h01;
      bus_if.dat_r <= v;
    end else begin
      bus_if.dat_r <= 8'd0;
    end
  end

  // Bus monitor: scoreboard for writes, counters for status and data reads.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_if.we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bus_write: unexpected write adr=0x%0h dat=0x%0h, required none",
                   bus_if.adr, bus_if.dat_w);
        end else begin
          check("bus_write", {10'd0, bus_if.adr, bus_if.dat_w}, exp_q.pop_front());
        end
      end else if (reg_a == 9'd12) begin
        polls++;
      end else if (reg_a >= 9'd5 && reg_a <= 9'd8) begin
        dreads++;
      end
    end
  end

  task automatic push_w(input int r, input int d);
    exp_q.push_back((32'(PAGE) << 17) | (32'(r) << 8) | 32'(d & 255));
  endtask

  task automatic push_cfg(input vec_t v);
    push_w(10, int'(v.len));
    for (int b = 0; b < 4; b++) push_w(1 + b, int'(byte_of(v.addr, b)));
  endtask

  task automatic push_run(input vec_t v);
    logic [31:0] p;
    int m;
    m = (v.mode == 2'd3) ? 2 : int'(v.mode);
    if (v.len == 8'd0 || int'(v.len) > MAX_BURST) return;
    push_cfg(v);
    if (m == 1) begin
      push_w(11, 1);
    end else begin
      p = v.seed;
      for (int i = 0; i < int'(v.len); i++) begin
        push_w(9, i);
        for (int b = 0; b < WB; b++) push_w(5 + b, int'(byte_of(p, b)));
        p = p + 32'h0101_0101;
      end
      push_w(11, 0);
      if (v.stuck) return;
      if (m == 2) begin
        push_cfg(v);
        push_w(11, 1);
      end
    end
    if (m != 0) for (int i = 0; i < int'(v.len); i++) push_w(9, i);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int n;
    bit seen;
    cfg_busy_n = v.busy_n; cfg_stuck = v.stuck; cfg_corrupt = v.corrupt;
    polls = 0; dreads = 0;
    push_run(v);
    @(negedge clk);
    mode = v.mode; burst_len = v.len; sdram_addr = v.addr; seed = v.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("r%0d_busy_after_start", k), 32'(busy), 32'd1);
    n = 0; seen = 1'b0;
    while (!seen && n < 4000) begin
      if (done) seen = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    check($sformatf("r%0d_done_seen", k), 32'(seen), 32'd1);
    if (v.e_cfg) check($sformatf("r%0d_cfg_done_latency_le2", k), 32'(n <= 2), 32'd1);
    check($sformatf("r%0d_pass", k), 32'(pass), 32'(v.e_pass));
    check($sformatf("r%0d_cfg_err", k), 32'(cfg_err), 32'(v.e_cfg));
    check($sformatf("r%0d_timeout", k), 32'(timeout), 32'(v.e_to));
    check($sformatf("r%0d_err_count", k), 32'(err_count), 32'(v.e_errs));
    check($sformatf("r%0d_first_err_idx", k), 32'(first_err_idx), 32'(v.e_first));
    check($sformatf("r%0d_busy_at_done", k), 32'(busy), 32'd0);
    check($sformatf("r%0d_status_polls", k), 32'(polls), 32'(v.e_polls));
    check($sformatf("r%0d_data_reads", k), 32'(dreads), 32'(v.e_reads));
    check($sformatf("r%0d_writes_left", k), 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check($sformatf("r%0d_done_one_cycle", k), 32'(done), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
    check({tag, "_first_err_idx"}, 32'(first_err_idx), 32'hFF);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_adr"}, 32'(bus_if.adr), 32'h200);
    check({tag, "_we"}, 32'(bus_if.we), 32'd0);
    check({tag, "_dat_w"}, 32'(bus_if.dat_w), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    vec_t rv;
    //          mode len   addr          seed          bsy stk cor  pass cfg to  errs  first  polls reads
    vecs[0] = '{2'd0, 8'd8, 32'h0000_0010, 32'h0000_1122, 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 21, 0};
    vecs[1] = '{2'd2, 8'd4, 32'h0000_2000, 32'hA5A5_0F0F, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 8, 16};
    vecs[2] = '{2'd2, 8'd4, 32'h1234_5678, 32'h0BAD_F00D, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd2, 6, 16};
    vecs[3] = '{2'd1, 8'd3, 32'h0000_0400, 32'h0000_0000, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 2, 12};
    vecs[4] = '{2'd0, 8'd0, 32'h0000_0000, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'hFF, 0, 0};
    vecs[5] = '{2'd2, 8'd9, 32'h0000_0000, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'hFF, 0, 0};
    vecs[6] = '{2'd3, 8'd2, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 2, 8};
    vecs[7] = '{2'd0, 8'd2, 32'h0000_0080, 32'h0000_0042, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'hFF, 24, 0};
    vecs[8] = '{2'd2, 8'd1, 32'h0000_0100, 32'h7777_7777, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'hFF, 2, 4};

    repeat (3) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // Start during the post-reset wait must be ignored.
    repeat (9) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("early_start_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("early_start_busy_later", 32'(busy), 32'd0);
    check("early_start_state", 32'(state), 32'd0);
    repeat (INIT_WAIT) @(negedge clk);

    for (int k = 0; k < 9; k++) run_vec(k, vecs[k]);

    // Async reset in the middle of the buffer fill abandons the run silently.
    rv = vecs[0];
    cfg_busy_n = 5; cfg_stuck = 1'b0; cfg_corrupt = 1'b0;
    push_run(rv);
    @(negedge clk);
    mode = rv.mode; burst_len = rv.len; sdram_addr = rv.addr; seed = rv.seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("midrun_busy_before_reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrun_rst");
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrun_no_done_pulse", 32'(done_cnt), 32'd0);
    repeat (INIT_WAIT) @(negedge clk);
    run_vec(9, vecs[1]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
